// File: rtl/goertzel_bank_n.sv
// Multi-channel Goertzel filter bank: per-block coefficient load, sample accumulation,
// then a two-stage magnitude pipeline. Define GOERTZEL_MAG_SAT_EN to saturate magnitudes instead of wrapping.
module goertzel_bank_n #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SAMP_W    = 8,
    parameter int unsigned BLOCK_N   = 64,
    parameter int unsigned COEFF_W   = 16,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned MAG_W     = 16,
    parameter int unsigned MAG_SHIFT = 0
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        enable,
    input  logic                        samp_valid,
    input  logic [SAMP_W-1:0]           samp_data,
    input  logic [NUM_CH*COEFF_W-1:0]   coeff_in,
    input  logic                        coeff_valid,
    output logic                        coeff_ready,
    output logic [NUM_CH*MAG_W-1:0]     mag_out,
    output logic                        mag_valid,
    input  logic                        mag_ready,
    output logic                        busy,
    output logic                        ovf
);

    localparam int unsigned CNT_W  = (BLOCK_N > 1) ? $clog2(BLOCK_N) : 1;
    localparam int unsigned FULL_W = ACC_W + COEFF_W + 2;
    localparam int unsigned PROD_W = 2 * ACC_W + COEFF_W;
    localparam int unsigned QSH    = COEFF_W - 2;

`ifdef GOERTZEL_MAG_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_MAG_MUL,
        S_MAG_SUM,
        S_HOLD
    } state_t;

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic signed [COEFF_W-1:0]  r_coeff [NUM_CH];
    logic signed [ACC_W-1:0]    r_s1    [NUM_CH];
    logic signed [ACC_W-1:0]    r_s2    [NUM_CH];
    logic signed [PROD_W-1:0]   r_p11   [NUM_CH];
    logic signed [PROD_W-1:0]   r_p22   [NUM_CH];
    logic signed [PROD_W-1:0]   r_pc    [NUM_CH];
    logic signed [PROD_W-1:0]   r_psum  [NUM_CH];

    logic signed [SAMP_W-1:0]   w_x;
    logic signed [FULL_W-1:0]   w_full  [NUM_CH];
    logic signed [ACC_W-1:0]    w_s     [NUM_CH];
    logic [NUM_CH-1:0]          w_ovf;
    logic signed [PROD_W-1:0]   w_p11   [NUM_CH];
    logic signed [PROD_W-1:0]   w_p22   [NUM_CH];
    logic signed [PROD_W-1:0]   w_pc    [NUM_CH];
    logic signed [PROD_W-1:0]   w_psum  [NUM_CH];
    logic signed [PROD_W-1:0]   w_shift [NUM_CH];
    logic [NUM_CH*MAG_W-1:0]    w_mag;

    // Recurrence step at full precision, then wrap to ACC_W and flag loss of range
    always_comb begin
        w_x   = {~samp_data[SAMP_W-1], samp_data[SAMP_W-2:0]};
        w_ovf = '0;
        w_mag = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            w_full[k]  = FULL_W'(w_x)
                       + ((FULL_W'(r_coeff[k]) * FULL_W'(r_s1[k])) >>> QSH)
                       - FULL_W'(r_s2[k]);
            w_s[k]     = w_full[k][ACC_W-1:0];
            w_ovf[k]   = (w_full[k] != FULL_W'(w_s[k]));
            w_p11[k]   = PROD_W'(r_s1[k]) * PROD_W'(r_s1[k]);
            w_p22[k]   = PROD_W'(r_s2[k]) * PROD_W'(r_s2[k]);
            w_pc[k]    = PROD_W'(r_coeff[k]) * PROD_W'(r_s1[k]) * PROD_W'(r_s2[k]);
            w_psum[k]  = r_p11[k] + r_p22[k] - (r_pc[k] >>> QSH);
            w_shift[k] = r_psum[k] >>> MAG_SHIFT;
            if (w_shift[k][PROD_W-1]) begin
                w_mag[k*MAG_W +: MAG_W] = '0;
            end else if (SAT_EN && (|w_shift[k][PROD_W-2:MAG_W])) begin
                w_mag[k*MAG_W +: MAG_W] = '1;
            end else begin
                w_mag[k*MAG_W +: MAG_W] = w_shift[k][MAG_W-1:0];
            end
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            coeff_ready <= 1'b0;
            mag_valid   <= 1'b0;
            busy        <= 1'b0;
            ovf         <= 1'b0;
            mag_out     <= '0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                r_coeff[k] <= '0;
                r_s1[k]    <= '0;
                r_s2[k]    <= '0;
                r_p11[k]   <= '0;
                r_p22[k]   <= '0;
                r_pc[k]    <= '0;
                r_psum[k]  <= '0;
            end
        end else if (!enable) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            coeff_ready <= 1'b0;
            mag_valid   <= 1'b0;
            busy        <= 1'b0;
            for (int k = 0; k < int'(NUM_CH); k++) begin
                r_s1[k] <= '0;
                r_s2[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_LOAD;
                    coeff_ready <= 1'b1;
                end
                S_LOAD: begin
                    if (coeff_valid) begin
                        r_state     <= S_ACCUM;
                        coeff_ready <= 1'b0;
                        busy        <= 1'b1;
                        ovf         <= 1'b0;
                        r_cnt       <= '0;
                        for (int k = 0; k < int'(NUM_CH); k++) begin
                            r_coeff[k] <= coeff_in[k*COEFF_W +: COEFF_W];
                            r_s1[k]    <= '0;
                            r_s2[k]    <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    if (samp_valid) begin
                        for (int k = 0; k < int'(NUM_CH); k++) begin
                            r_s2[k] <= r_s1[k];
                            r_s1[k] <= w_s[k];
                        end
                        if (|w_ovf) begin
                            ovf <= 1'b1;
                        end
                        if (r_cnt == CNT_W'(BLOCK_N - 1)) begin
                            r_state <= S_MAG_MUL;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_MAG_MUL: begin
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        r_p11[k] <= w_p11[k];
                        r_p22[k] <= w_p22[k];
                        r_pc[k]  <= w_pc[k];
                    end
                    r_state <= S_MAG_SUM;
                end
                S_MAG_SUM: begin
                    for (int k = 0; k < int'(NUM_CH); k++) begin
                        r_psum[k] <= w_psum[k];
                    end
                    r_state <= S_HOLD;
                    busy    <= 1'b0;
                end
                S_HOLD: begin
                    // First HOLD cycle registers the clamped result; afterwards wait for the consumer
                    if (!mag_valid) begin
                        mag_out   <= w_mag;
                        mag_valid <= 1'b1;
                    end else if (mag_ready) begin
                        mag_valid   <= 1'b0;
                        coeff_ready <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
